alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 a  input  WIDTH  operand A; two's complement for signed flags.
REQ-005 b  input  WIDTH  operand B; two's complement for signed flags.
REQ-006 op  input  3  operation select.
REQ-007 x  output  WIDTH  registered result.
REQ-008 flag  output  4  registered flags: [0]=Z zero, [1]=N negative, [2]=C carry/borrow/shift-out, [3]=V signed overflow.

Function
REQ-009 The block SHALL sample a, b and op on every rising clk edge and present x and flag on the next edge, with a latency of one cycle and no handshake.
REQ-010 op=0 ADD: x = a+b mod 2^WIDTH; C = carry out of the MSB; V = 1 when the operand signs match and the result sign differs.
REQ-011 op=1 SUB: x = a-b mod 2^WIDTH; C = borrow, meaning 1 when a<b unsigned; V = 1 when the operand signs differ and the result sign differs from a.
REQ-012 op=2 AND: x = a&b; C=0; V=0.
REQ-013 op=3 OR: x = a|b; C=0; V=0.
REQ-014 op=4 XOR: x = a^b; C=0; V=0.
REQ-015 op=5 NOT: x = ~a, b ignored; C=0; V=0.
REQ-016 op=6 SHL: x = a<<1 with zero fill; C = a[WIDTH-1]; V=0; b ignored.
REQ-017 op=7 SHR: x = a>>1, logical with zero fill; C = a[0]; V=0; b ignored.
REQ-018 For every op, Z SHALL be 1 exactly when the WIDTH-bit x is zero, and N SHALL equal x[WIDTH-1].
REQ-019 The block SHALL hold no state other than the x and flag registers, so each cycle's result depends only on the previous cycle's inputs.
REQ-020 Back-to-back op changes SHALL each produce the correct result one cycle later, with no bubbles.

Reset
REQ-021 While rst=1 at a clk edge, x SHALL load 0 and flag SHALL load 4'b0000; the zero result is not reflected in Z during reset.
REQ-022 The first edge with rst=0 SHALL register the result of the inputs present at that edge.
REQ-023 Asserting rst mid-stream SHALL discard the pending result, with no partial or stale value appearing after reset deasserts.

Structure
REQ-024 A shared package alu_pkg SHALL hold the op encoding constants (OP_ADD..OP_SHR = 0..7) and the flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3).
REQ-025 A combinational sub-module alu_datapath SHALL compute the next x and flags, and alu SHALL contain only the output registers and the reset logic.

Verification
REQ-026 a=3, b=2, op=0 -> next cycle x=5, flag=0000.
REQ-027 a=64, b=64, op=0 -> x=128 (0x80), N=1, V=1, C=0, Z=0; a=2, b=2, op=1 -> x=0, Z=1, C=0, V=0.
REQ-028 a=0x82 (-126), b=0xFD (-3), op=1 -> x=0x85 (-123), N=1, C=1, V=0, Z=0.
REQ-029 a=64, b=64 with op=2..7 -> x = 0x40, 0x40, 0x00 (Z=1), 0xBF (N=1), 0x80 (N=1, C=0), 0x20 (C=0), each one cycle after its op.
REQ-030 Reset checks: rst=1 during an ADD stream -> x=0 and flag=0000 at the next edge; after rst=0, the first result matches the inputs present at the release edge.
REQ-031 Randomized check: a, b, op applied back-to-back and compared against a reference model with one-cycle delay, including a=0x7F, b=0x01 ADD (V=1) and a=0x80, b=0x01 SUB (V=1).

Source files
------------

// File: rtl/alu_pkg.sv
// ALU shared definitions: operation encoding and flag bit positions.
// Imported by the datapath and the registered top.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_datapath.sv
// ALU combinational datapath: next result and Z/N/C/V flags.
// Purely combinational; all state lives in the alu top.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] x_nxt,
  output logic [3:0]       flag_nxt
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;

  // Widened by one bit so the top bit is carry (add) or borrow (sub).
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    unique case (op)
      OP_ADD: begin
        res = sum[MSB:0];
        c   = sum[WIDTH];
        v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res = dif[MSB:0];
        c   = dif[WIDTH];
        v   = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: begin
        res = {a[MSB-1:0], 1'b0};
        c   = a[MSB];
      end
      OP_SHR: begin
        res = {1'b0, a[MSB:1]};
        c   = a[0];
      end
      default: begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
      end
    endcase
  end

  always_comb begin
    x_nxt            = res;
    flag_nxt         = '0;
    flag_nxt[FLAG_Z] = (res == '0);
    flag_nxt[FLAG_N] = res[MSB];
    flag_nxt[FLAG_C] = c;
    flag_nxt[FLAG_V] = v;
  end

endmodule

// File: rtl/alu.sv
// ALU top: one-cycle registered result and flags.
// Synchronous active-high reset clears both registers.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] x,
  output logic [3:0]       flag
);

  logic [WIDTH-1:0] x_nxt;
  logic [3:0]       flag_nxt;

  alu_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .a       (a),
    .b       (b),
    .op      (op),
    .x_nxt   (x_nxt),
    .flag_nxt(flag_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x    <= '0;
      flag <= 4'b0000;
    end else begin
      x    <= x_nxt;
      flag <= flag_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed vectors plus randomized back-to-back
// stimulus compared against an arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic [W-1:0] x;
  logic [3:0]   flag;

  int total = 0;
  int bad   = 0;

  alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .op  (op),
    .x   (x),
    .flag(flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Model: returns {flag, x} from plain integer arithmetic.
  function automatic logic [11:0] model(input int ia, input int ib,
                                        input int iop);
    int r;
    int s;
    int c;
    int v;
    c = 0;
    v = 0;
    r = 0;
    case (iop)
      0: begin
        r = ia + ib;
        c = (r > 255) ? 1 : 0;
        s = sx(ia) + sx(ib);
        v = (s > 127 || s < -128) ? 1 : 0;
      end
      1: begin
        r = ia - ib + 256;
        c = (ia < ib) ? 1 : 0;
        s = sx(ia) - sx(ib);
        v = (s > 127 || s < -128) ? 1 : 0;
      end
      2: r = ia & ib;
      3: r = ia | ib;
      4: r = ia ^ ib;
      5: r = 255 - ia;
      6: begin
        r = ia * 2;
        c = (ia >= 128) ? 1 : 0;
      end
      default: begin
        r = ia / 2;
        c = ia % 2;
      end
    endcase
    r = r % 256;
    model = {v[0], c[0], (r >= 128), (r == 0), r[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one edge, then sample just after it.
  task automatic step(input logic r, input logic [7:0] ia,
                      input logic [7:0] ib, input logic [2:0] iop);
    rst = r;
    a   = ia;
    b   = ib;
    op  = iop;
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag, input logic [7:0] ia,
                     input logic [7:0] ib, input logic [2:0] iop,
                     input logic [7:0] ex, input logic [3:0] ef);
    step(1'b0, ia, ib, iop);
    chk({tag, "_x"}, x, ex);
    chk({tag, "_f"}, {4'b0, flag}, {4'b0, ef});
  endtask

  initial begin
    logic [11:0] e;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [2:0]  rop;
    logic        rr;

    step(1'b1, 8'h00, 8'h00, OP_ADD);
    step(1'b1, 8'hFF, 8'hFF, OP_ADD);
    chk("rst_x", x, 8'h00);
    chk("rst_f", {4'b0, flag}, 8'h00);

    // flag order is {V,C,N,Z}
    dir("add35",   8'd3,  8'd2,  OP_ADD, 8'd5,  4'b0000);
    dir("add_ovf", 8'd64, 8'd64, OP_ADD, 8'h80, 4'b1010);
    dir("sub_z",   8'd2,  8'd2,  OP_SUB, 8'h00, 4'b0001);
    dir("sub_neg", 8'h82, 8'hFD, OP_SUB, 8'h85, 4'b0110);
    dir("and",     8'd64, 8'd64, OP_AND, 8'h40, 4'b0000);
    dir("or",      8'd64, 8'd64, OP_OR,  8'h40, 4'b0000);
    dir("xor",     8'd64, 8'd64, OP_XOR, 8'h00, 4'b0001);
    dir("not",     8'd64, 8'd64, OP_NOT, 8'hBF, 4'b0010);
    dir("shl",     8'd64, 8'd64, OP_SHL, 8'h80, 4'b0010);
    dir("shr",     8'd64, 8'd64, OP_SHR, 8'h20, 4'b0000);
    dir("add7f",   8'h7F, 8'h01, OP_ADD, 8'h80, 4'b1010);
    dir("sub80",   8'h80, 8'h01, OP_SUB, 8'h7F, 4'b1000);
    dir("shl_c",   8'hC1, 8'h00, OP_SHL, 8'h82, 4'b0110);
    dir("shr_c",   8'h01, 8'h00, OP_SHR, 8'h00, 4'b0101);
    dir("sub_brw", 8'h00, 8'h01, OP_SUB, 8'hFF, 4'b0110);
    dir("add_c",   8'hFF, 8'h01, OP_ADD, 8'h00, 4'b0101);

    // Reset in the middle of an ADD stream, then release.
    dir("pre_rst", 8'd10, 8'd20, OP_ADD, 8'd30, 4'b0000);
    step(1'b1, 8'd40, 8'd50, OP_ADD);
    chk("mid_rst_x", x, 8'h00);
    chk("mid_rst_f", {4'b0, flag}, 8'h00);
    step(1'b0, 8'h90, 8'h90, OP_ADD);
    e = model(32'h90, 32'h90, 0);
    chk("rel_x", x, e[7:0]);
    chk("rel_f", {4'b0, flag}, {4'b0, e[11:8]});

    for (int i = 0; i < 300; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 3'($urandom);
      rr  = ($urandom_range(0, 19) == 0);
      step(rr, ra, rb, rop);
      e = rr ? 12'h000 : model(int'(ra), int'(rb), int'(rop));
      chk("rnd_x", x, e[7:0]);
      chk("rnd_f", {4'b0, flag}, {4'b0, e[11:8]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
